// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the two-port SRAM arbiter/controller.
// Pin levels for each FSM state live here so the top only registers them.
package sram_arb_pkg;

    localparam int ADDR_W_DEFAULT = 19;
    localparam int DATA_W         = 8;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } state_t;

    typedef struct packed {
        logic ceb;
        logic oeb;
        logic rnw;
        logic data_oe;
    } pins_t;

    localparam pins_t PINS_QUIET = '{ceb: 1'b1, oeb: 1'b1, rnw: 1'b1, data_oe: 1'b0};

    // Strobe counter load value; out-of-range settings are clamped to 1..15 cycles.
    function automatic logic [3:0] strobe_load(input int wait_cycles);
        int w;
        w = wait_cycles;
        if (w < 1)  w = 1;
        if (w > 15) w = 15;
        return 4'(w - 1);
    endfunction

    function automatic pins_t pins_for(input state_t st, input logic rnw);
        pins_t p;
        p = PINS_QUIET;
        case (st)
            STROBE: begin
                p.ceb     = 1'b0;
                p.oeb     = ~rnw;
                p.rnw     = rnw;
                p.data_oe = ~rnw;
            end
            // Write data is held one cycle past the write strobe.
            HOLD:    p.data_oe = ~rnw;
            default: p = PINS_QUIET;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/sram_arb_ctrl_rr_arb2.sv
// Two-way round-robin grant: a tie goes to the port that did not win last.
// req[0] is port A, req[1] is port B.
module rr_arb2
    import sram_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant,
    output logic       valid
);

    always_comb begin
        valid = |req;
        grant = PORT_A;
        if (req == 2'b11) begin
            grant = ~last_grant;
        end else if (req[1]) begin
            grant = PORT_B;
        end
    end

endmodule

// File: rtl/sram_arb_ctrl.sv
// Owner of the asynchronous 512K x 8 SRAM pins: arbitrates ports A/B round-robin
// and sequences setup / strobe window / hold, returning a one-cycle ack per access.
module sram_arb_ctrl
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEFAULT,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              resetb,

    input  logic              a_req,
    input  logic              a_rnw,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [7:0]        a_wdata,
    output logic              a_ack,
    output logic [7:0]        a_rdata,

    input  logic              b_req,
    input  logic              b_rnw,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [7:0]        b_wdata,
    output logic              b_ack,
    output logic [7:0]        b_rdata,

    output logic [ADDR_W-1:0] ram_addr,
    inout  wire  [7:0]        ram_data,
    output logic              ram_ceb,
    output logic              ram_oeb,
    output logic              ram_rnw
);

    localparam logic [3:0] CNT_LOAD = strobe_load(WAIT_CYCLES);

    state_t            state_q;
    state_t            state_d;
    logic [3:0]        cnt_q;
    logic [3:0]        cnt_d;
    logic              latch_en;
    logic              strobe_done;

    logic              last_grant_q;
    logic              arb_grant;
    logic              arb_valid;

    logic              lat_port;
    logic              lat_rnw;
    logic [7:0]        lat_wdata;
    logic [ADDR_W-1:0] ram_addr_q;

    pins_t             pins_q;
    pins_t             pins_d;

    logic              a_ack_q;
    logic              b_ack_q;
    logic [7:0]        a_rdata_q;
    logic [7:0]        b_rdata_q;

    rr_arb2 u_arb (
        .req        ({b_req, a_req}),
        .last_grant (last_grant_q),
        .grant      (arb_grant),
        .valid      (arb_valid)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        latch_en = 1'b0;
        case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    state_d  = SETUP;
                    latch_en = 1'b1;
                end
            end
            SETUP: begin
                state_d = STROBE;
                cnt_d   = CNT_LOAD;
            end
            STROBE: begin
                if (cnt_q == 4'd0) begin
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            HOLD: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Last strobe cycle: data is sampled and ack raised at this edge, both visible in HOLD.
    assign strobe_done = (state_q == STROBE) && (cnt_q == 4'd0);
    assign pins_d      = pins_for(state_d, lat_rnw);

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            last_grant_q <= PORT_B;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (latch_en) begin
                last_grant_q <= arb_grant;
            end
        end
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            lat_port   <= PORT_A;
            lat_rnw    <= 1'b1;
            lat_wdata  <= 8'h00;
            ram_addr_q <= '0;
        end else if (latch_en) begin
            lat_port   <= arb_grant;
            lat_rnw    <= (arb_grant == PORT_B) ? b_rnw   : a_rnw;
            lat_wdata  <= (arb_grant == PORT_B) ? b_wdata : a_wdata;
            ram_addr_q <= (arb_grant == PORT_B) ? b_addr  : a_addr;
        end
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            pins_q <= PINS_QUIET;
        end else begin
            pins_q <= pins_d;
        end
    end

    // Only the granted port's ack/rdata move; the other side keeps its last value.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            a_ack_q   <= 1'b0;
            b_ack_q   <= 1'b0;
            a_rdata_q <= 8'h00;
            b_rdata_q <= 8'h00;
        end else begin
            a_ack_q <= strobe_done && (lat_port == PORT_A);
            b_ack_q <= strobe_done && (lat_port == PORT_B);
            if (strobe_done && lat_rnw) begin
                if (lat_port == PORT_A) begin
                    a_rdata_q <= ram_data;
                end else begin
                    b_rdata_q <= ram_data;
                end
            end
        end
    end

    assign ram_addr = ram_addr_q;
    assign ram_ceb  = pins_q.ceb;
    assign ram_oeb  = pins_q.oeb;
    assign ram_rnw  = pins_q.rnw;
    assign ram_data = pins_q.data_oe ? lat_wdata : 8'bzzzz_zzzz;

    assign a_ack   = a_ack_q;
    assign b_ack   = b_ack_q;
    assign a_rdata = a_rdata_q;
    assign b_rdata = b_rdata_q;

endmodule
